// File: rtl/a2d_sequencer_if.sv
// SPI master handshake shared by the A2D sequencer: start pulse and command
// out, completion pulse and shifted-in data back.
interface a2d_sequencer_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (
    output wrt,
    output cmd,
    input  done,
    input  rd_data
  );

  modport slave (
    input  wrt,
    input  cmd,
    output done,
    output rd_data
  );
endinterface

// File: rtl/a2d_sequencer.sv
// Round-robin A2D conversion scheduler: every interval runs a channel-select
// then a result-read SPI transaction for the next sensor and holds the result.
module a2d_sequencer #(
  parameter logic       FAST_SIM  = 1'b0,
  parameter logic [2:0] CH_BATT   = 3'd0,
  parameter logic [2:0] CH_CURR   = 3'd1,
  parameter logic [2:0] CH_BRAKE  = 3'd3,
  parameter logic [2:0] CH_TORQUE = 3'd4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  a2d_sequencer_if.master        spi,
  output logic [11:0]            batt,
  output logic [11:0]            curr,
  output logic [11:0]            brake,
  output logic [11:0]            torque,
  output logic                   cnv_cmplt,
  output logic [1:0]             ch_idx
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAIT1,
    GAP,
    READ,
    WAIT2,
    STORE
  } state_e;

  state_e      state_q;
  logic [13:0] timer_q;
  logic        pending_q;
  logic        wrt_q;
  logic [15:0] cmd_q;
  logic        cnv_cmplt_q;
  logic [1:0]  ch_idx_q;
  logic [11:0] res_q [4];

  logic        trigger;
  logic [2:0]  chan;
  logic [3:0]  rd_unused;

  assign trigger   = FAST_SIM ? (&timer_q[9:0]) : (&timer_q);
  assign rd_unused = spi.rd_data[15:12];

  always_comb begin
    chan = CH_BATT;
    unique case (ch_idx_q)
      2'd0: chan = CH_BATT;
      2'd1: chan = CH_CURR;
      2'd2: chan = CH_BRAKE;
      2'd3: chan = CH_TORQUE;
      default: chan = CH_BATT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 14'd1;
    end
  end

  // A trigger arriving while IDLE starts the conversion directly, so pending
  // only ever holds a trigger that landed while a conversion was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      wrt_q       <= 1'b0;
      cmd_q       <= '0;
      cnv_cmplt_q <= 1'b0;
      ch_idx_q    <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      wrt_q       <= 1'b0;
      cnv_cmplt_q <= 1'b0;
      if (trigger) begin
        pending_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (pending_q || trigger) begin
            state_q   <= CMD;
            pending_q <= 1'b0;
            wrt_q     <= 1'b1;
            cmd_q     <= {2'b00, chan, 11'h000};
          end
        end
        CMD: state_q <= WAIT1;
        WAIT1: begin
          if (spi.done) begin
            state_q <= GAP;
          end
        end
        GAP: begin
          state_q <= READ;
          wrt_q   <= 1'b1;
          cmd_q   <= '0;
        end
        READ: state_q <= WAIT2;
        WAIT2: begin
          if (spi.done) begin
            state_q <= STORE;
          end
        end
        STORE: begin
          res_q[ch_idx_q] <= spi.rd_data[11:0];
          cnv_cmplt_q     <= 1'b1;
          ch_idx_q        <= ch_idx_q + 2'd1;
          state_q         <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi.wrt   = wrt_q;
  assign spi.cmd   = cmd_q;
  assign batt      = res_q[0];
  assign curr      = res_q[1];
  assign brake     = res_q[2];
  assign torque    = res_q[3];
  assign cnv_cmplt = cnv_cmplt_q;
  assign ch_idx    = ch_idx_q;

endmodule
